chimp_board_renderer: RTL and testbench



---
 rtl/chimp_board_renderer.sv | 212 +++++++++++++++++++++
 tb/tb_chimp_board_renderer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chimp_board_renderer.sv
// Streams the 8x8 chimp board to the VGA plotter, one valid/ready pixel at a time.
// Optional CHIMP_RENDER_DIRTY_EN skips cells that are unchanged since they were last drawn.
module chimp_board_renderer #(
    parameter int         CELL_PX    = 12,
    parameter int         GAP        = 2,
    parameter int         ORIGIN_X   = 8,
    parameter int         ORIGIN_Y   = 8,
    parameter logic [2:0] COL_BG     = 3'b000,
    parameter logic [2:0] COL_HIDDEN = 3'b111,
    parameter logic [2:0] COL_SHOWN  = 3'b011
) (
    input  logic         clk,
    input  logic         iReset,
    input  logic [447:0] iBoard,
    input  logic         iStart,
    input  logic         iPlotReady,
    output logic [7:0]   oX,
    output logic [6:0]   oY,
    output logic [2:0]   oColour,
    output logic         oPlot,
    output logic         oBusy,
    output logic         oDone
);

    localparam int PW = $clog2(CELL_PX + 1);
    localparam logic [PW-1:0] LAST_P = PW'(CELL_PX - 1);
    localparam logic [PW-1:0] EDGE_P = PW'(CELL_PX - GAP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_CELL  = 3'd2,
        S_DRAW  = 3'd3,
        S_NEXT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t         state_q;
    logic [447:0]   snap_q;
    logic [5:0]     cell_q;
    logic [PW-1:0]  px_q, py_q;
    logic [2:0]     cell_col_q;
    logic [7:0]     x_q;
    logic [6:0]     y_q;
    logic [2:0]     colour_q;
    logic           plot_q, busy_q, done_q;

    logic [6:0]     snap_cells [64];
    logic [2:0]     cell_x, cell_y;
    logic [5:0]     cell_idx;
    logic [6:0]     cell_val;
    logic [2:0]     cell_col;
    logic           cell_skip;
    logic           last_pix, accept;

    logic [PW-1:0]  px_d, py_d;
    logic [2:0]     base_col;
    logic [7:0]     x_d;
    logic [6:0]     y_d;
    logic [2:0]     colour_d;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_snap
            assign snap_cells[gi] = snap_q[gi*7 +: 7];
        end
    endgenerate

    // Board storage is x-major, while the walk is y-major with x fastest.
    assign cell_x   = cell_q[2:0];
    assign cell_y   = cell_q[5:3];
    assign cell_idx = {cell_x, cell_y};
    assign cell_val = snap_cells[cell_idx];
    assign last_pix = (px_q == LAST_P) && (py_q == LAST_P);
    assign accept   = plot_q && iPlotReady;

    always_comb begin
        cell_col = COL_BG;
        if (cell_val[6]) begin
            cell_col = cell_val[5] ? COL_SHOWN : COL_HIDDEN;
        end
    end

    // Pixel to present next: the cell's first pixel from CELL, the successor from DRAW.
    always_comb begin
        px_d     = '0;
        py_d     = '0;
        base_col = cell_col;
        if (state_q != S_CELL) begin
            base_col = cell_col_q;
            if (px_q == LAST_P) begin
                py_d = py_q + PW'(1);
            end else begin
                px_d = px_q + PW'(1);
                py_d = py_q;
            end
        end
        x_d      = 8'(ORIGIN_X) + 8'(cell_x) * 8'(CELL_PX) + 8'(px_d);
        y_d      = 7'(ORIGIN_Y) + 7'(cell_y) * 7'(CELL_PX) + 7'(py_d);
        colour_d = ((px_d >= EDGE_P) || (py_d >= EDGE_P)) ? COL_BG : base_col;
    end

`ifdef CHIMP_RENDER_DIRTY_EN
    logic [447:0] shadow_q;
    logic [63:0]  shadow_vld_q;
    logic [6:0]   shadow_cells [64];
    logic [8:0]   cell_base;

    generate
        for (gi = 0; gi < 64; gi++) begin : g_shadow
            assign shadow_cells[gi] = shadow_q[gi*7 +: 7];
        end
    endgenerate

    assign cell_base = 9'(cell_idx) * 9'd7;
    assign cell_skip = shadow_vld_q[cell_idx] && (shadow_cells[cell_idx] == cell_val);

    always_ff @(posedge clk) begin
        if (iReset) begin
            shadow_q     <= '0;
            shadow_vld_q <= '0;
        end else if ((state_q == S_DRAW) && accept && last_pix) begin
            shadow_q[cell_base +: 7] <= cell_val;
            shadow_vld_q[cell_idx]   <= 1'b1;
        end
    end
`else
    assign cell_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            snap_q     <= '0;
            cell_q     <= '0;
            px_q       <= '0;
            py_q       <= '0;
            cell_col_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iStart) begin
                        busy_q  <= 1'b1;
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    snap_q  <= iBoard;
                    cell_q  <= '0;
                    state_q <= S_CELL;
                end
                S_CELL: begin
                    if (cell_skip) begin
                        state_q <= S_NEXT;
                    end else begin
                        px_q       <= px_d;
                        py_q       <= py_d;
                        cell_col_q <= cell_col;
                        x_q        <= x_d;
                        y_q        <= y_d;
                        colour_q   <= colour_d;
                        plot_q     <= 1'b1;
                        state_q    <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (accept) begin
                        if (last_pix) begin
                            plot_q  <= 1'b0;
                            state_q <= S_NEXT;
                        end else begin
                            px_q     <= px_d;
                            py_q     <= py_d;
                            x_q      <= x_d;
                            y_q      <= y_d;
                            colour_q <= colour_d;
                        end
                    end
                end
                S_NEXT: begin
                    if (cell_q == 6'd63) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        cell_q  <= cell_q + 6'd1;
                        state_q <= S_CELL;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oX      = x_q;
    assign oY      = y_q;
    assign oColour = colour_q;
    assign oPlot   = plot_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;

endmodule

// File: tb/tb_chimp_board_renderer.sv
// Scoreboard bench for chimp_board_renderer: a board model queues expected pixels, a monitor checks them.
module tb_chimp_board_renderer;

    logic         clk;
    logic         iReset;
    logic [447:0] iBoard;
    logic         iStart;
    logic         iPlotReady;
    logic [7:0]   oX;
    logic [6:0]   oY;
    logic [2:0]   oColour;
    logic         oPlot;
    logic         oBusy;
    logic         oDone;

    chimp_board_renderer dut (
        .clk        (clk),
        .iReset     (iReset),
        .iBoard     (iBoard),
        .iStart     (iStart),
        .iPlotReady (iPlotReady),
        .oX         (oX),
        .oY         (oY),
        .oColour    (oColour),
        .oPlot      (oPlot),
        .oBusy      (oBusy),
        .oDone      (oDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    logic [17:0] exp_q [$];
    int          pix_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          first_cyc = 0;
    int          last_lat = 0;
    bit          got_first = 0;
    logic [14:0] first_xy, last_xy;
    logic [3:0]  probe_a, probe_b;
    bit          stall_mode = 0;
    bit          prev_stall = 0;
    logic [17:0] prev_pix;
    bit [3:0]    pat = 4'b1001;
    logic [6:0]  m_sh [64];
    bit          m_sv [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [447:0] put(input logic [447:0] b, input int x, input int y,
                                         input logic [6:0] v);
        logic [447:0] r;
        r = b;
        r[(x*8+y)*7 +: 7] = v;
        return r;
    endfunction

    // Board model: queues the expected pixel stream and predicts cycle counts for one frame.
    task automatic push_frame(input logic [447:0] b, output int npix, output int lat,
                              output int flat);
        npix = 0;
        lat  = 1;
        flat = 0;
        for (int cy = 0; cy < 8; cy++) begin
            for (int cx = 0; cx < 8; cx++) begin
                int k;
                logic [6:0] v;
                bit drawn;
                k = cx*8 + cy;
                v = b[k*7 +: 7];
                drawn = 1;
`ifdef CHIMP_RENDER_DIRTY_EN
                if (m_sv[k] && (m_sh[k] == v)) drawn = 0;
`endif
                if (!drawn) begin
                    lat += 2;
                end else begin
                    if (npix == 0) flat = lat + 2;
                    for (int py = 0; py < 12; py++) begin
                        for (int px = 0; px < 12; px++) begin
                            logic [2:0] c;
                            c = 3'b000;
                            if (px < 10 && py < 10 && v[6]) c = v[5] ? 3'b011 : 3'b111;
                            exp_q.push_back({8'(8 + cx*12 + px), 7'(8 + cy*12 + py), c});
                        end
                    end
                    npix += 144;
                    lat  += 146;
                    m_sh[k] = v;
                    m_sv[k] = 1;
                end
            end
        end
        lat += 1;
    endtask

    // Ready driver: all-ones, or a random draw from the 1,0,0,1 pattern while stalling.
    initial begin
        iPlotReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            iPlotReady = stall_mode ? pat[$urandom_range(0, 3)] : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted pixel, checks stall stability and oDone.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_stall)
                check("stall_hold", 32'({oPlot, oX, oY, oColour}), 32'({1'b1, prev_pix}));
            prev_stall = oPlot && !iPlotReady;
            prev_pix   = {oX, oY, oColour};
            if (oPlot && !got_first) begin
                got_first = 1;
                first_cyc = cyc;
            end
            if (oPlot && iPlotReady) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL extra_pixel: got (%0d,%0d) colour %0d, required no pixel", oX, oY, oColour);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    check("pixel", 32'({oX, oY, oColour}), 32'(e));
                end
                if (pix_cnt == 0) first_xy = {oX, oY};
                last_xy = {oX, oY};
                pix_cnt++;
                if (oX == 8'd32 && oY == 7'd68) probe_a = {1'b0, oColour};
                if (oX == 8'd42 && oY == 7'd68) probe_b = {1'b0, oColour};
            end
            if (oDone) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_frame(input string tag, input logic [447:0] b, input bit stall,
                             input bit poke, input bit check_lat);
        int npix, lat, flat, start, d0;
        bit ok;
        push_frame(b, npix, lat, flat);
        pix_cnt   = 0;
        got_first = 0;
        probe_a   = 4'hF;
        probe_b   = 4'hF;
        d0        = done_cnt;
        ok        = 0;
        stall_mode = stall;
        @(negedge clk);
        iBoard = b;
        iStart = 1'b1;
        start  = cyc;
        @(negedge clk);
        iStart = 1'b0;
        check({tag, "_busy"}, 32'(oBusy), 32'd1);
        for (int i = 0; i < lat*3 + 200; i++) begin
            @(negedge clk);
            if (poke && i == 40) begin
                iStart = 1'b1;
                iBoard = ~b;
            end
            if (poke && i == 41) iStart = 1'b0;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
        stall_mode = 0;
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        last_lat = done_cyc - start;
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_pixel_count"}, 32'(pix_cnt), 32'(npix));
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle_busy"}, 32'(oBusy), 32'd0);
        if (check_lat) check({tag, "_done_latency"}, 32'(last_lat), 32'(lat));
        if (npix > 0) check({tag, "_first_plot_latency"}, 32'(first_cyc - start), 32'(flat));
        exp_q.delete();
    endtask

    initial begin
        logic [447:0] b2, b3, b4, b5;
        int d0, start;
        bit ok;
        iReset = 1'b1;
        iStart = 1'b0;
        iBoard = '0;
        for (int k = 0; k < 64; k++) begin
            m_sv[k] = 0;
            m_sh[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_coords", 32'({oX, oY, oColour}), 32'd0);
        check("reset_flags", 32'({oPlot, oBusy, oDone}), 32'd0);
        iReset = 1'b0;
        repeat (2) @(negedge clk);

        // Blank board: every pixel background, fixed frame length.
        run_frame("zero", '0, 0, 0, 1);
        check("zero_first_xy", 32'(first_xy), 32'({8'd8, 7'd8}));
        check("zero_last_xy", 32'(last_xy), 32'({8'd103, 7'd103}));
        check("zero_total_pixels", 32'(pix_cnt), 32'd9216);
        check("zero_cycles", 32'(last_lat), 32'd9346);

        // One shown cell; iStart and iBoard disturbed mid-frame.
        b2 = put('0, 2, 5, 7'b1100011);
        run_frame("latch", b2, 0, 1, 1);
        check("shown_colour_32_68", 32'(probe_a), 32'h3);
        check("border_colour_42_68", 32'(probe_b), 32'h0);

        // Mixed board under random back-pressure; cell (2,5) now hidden.
        b3 = '0;
        for (int k = 0; k < 64; k++) b3[k*7 +: 7] = 7'((k*37 + 5) % 128);
        b3 = put(b3, 2, 5, 7'b1000011);
        run_frame("stall", b3, 1, 0, 0);
        check("hidden_colour_32_68", 32'(probe_a), 32'h7);
`ifndef CHIMP_RENDER_DIRTY_EN
        check("stall_total_pixels", 32'(pix_cnt), 32'd9216);
`endif

        // Reset at roughly pixel 500.
        b4 = b3 ^ {64{7'h01}};
        begin
            int npix, lat, flat;
            push_frame(b4, npix, lat, flat);
        end
        pix_cnt = 0;
        d0 = done_cnt;
        ok = 0;
        @(negedge clk);
        iBoard = b4;
        iStart = 1'b1;
        start  = cyc;
        @(negedge clk);
        iStart = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pix_cnt >= 500) begin
                ok = 1;
                break;
            end
        end
        check("reset_reach_500", 32'(ok), 32'd1);
        iReset = 1'b1;
        @(negedge clk);
        check("midreset_plot_busy", 32'({oPlot, oBusy}), 32'd0);
        check("midreset_outputs", 32'({oX, oY, oColour, oDone}), 32'd0);
        iReset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 64; k++) m_sv[k] = 0;
        repeat (30) @(negedge clk);
        check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
        check("midreset_idle", 32'(oBusy), 32'd0);

        // Full frame after the interrupted one.
        b5 = '0;
        for (int k = 0; k < 64; k++) b5[k*7 +: 7] = 7'((k*53 + 17) % 128);
        run_frame("after_reset", b5, 0, 0, 1);
        check("after_reset_pixels", 32'(pix_cnt), 32'd9216);
        check("after_reset_cycles", 32'(last_lat), 32'd9346);

`ifdef CHIMP_RENDER_DIRTY_EN
        run_frame("dirty_same", b5, 0, 0, 1);
        check("dirty_same_pixels", 32'(pix_cnt), 32'd0);
        check("dirty_same_cycles", 32'(last_lat), 32'd130);
        run_frame("dirty_one", put(b5, 4, 1, b5[(4*8+1)*7 +: 7] ^ 7'h10), 0, 0, 1);
        check("dirty_one_pixels", 32'(pix_cnt), 32'd144);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
